// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and busy scoreboard
//
// Purpose:
//   Register file for the pipelined seq core. NREAD combinational read
//   ports, one synchronous write port (writeback), optional same-cycle
//   write-to-read forwarding, and a per-register busy bit that decode
//   uses to spot reads of registers whose producer has not written back.
//
// Ports:
//   CLK       in   1             clock, rising edge
//   RST_N     in   1             asynchronous active-low reset
//   rd_addr   in   NREAD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   out  NREAD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy   out  NREAD         per-port pending-write flag
//   wr_en     in   1             writeback enable
//   wr_addr   in   ADDR_W        writeback destination
//   wr_data   in   DATA_W        writeback data
//   iss_en    in   1             instruction issues this cycle
//   iss_addr  in   ADDR_W        destination of the issuing instruction

module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic [NREAD*DATA_W-1:0] rd_data,
   output logic [NREAD-1:0]        rd_busy,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr
);

   localparam int              DEPTH  = 1 << ADDR_W;
   localparam bit              BYP_EN = (BYPASS != 0);
   localparam bit              ZR_EN  = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] REG0 = '0;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   // Writes are blanked while reset is asserted so the forwarding path
   // cannot leak wr_data onto rd_data during reset.
   logic wr_live;
   logic wr_commit;

   assign wr_live   = wr_en & RST_N;
   assign wr_commit = wr_en & ~(ZR_EN && (wr_addr == REG0));

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_q[r] <= '0;
         end
      end else if (wr_commit) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   // Clear is applied before set so that an issue and a writeback to the
   // same register in one cycle leaves it busy: the issuing instruction
   // is a newer producer than the one writing back.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (iss_en) begin
         busy_d[iss_addr] = 1'b1;
      end
      if (ZR_EN) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              zero_hit;
      logic              byp_hit;
      logic [DATA_W-1:0] port_data;
      logic              port_busy;

      assign addr     = rd_addr[g*ADDR_W +: ADDR_W];
      assign zero_hit = ZR_EN && (addr == REG0);
      assign byp_hit  = BYP_EN && wr_live && (wr_addr == addr);

      always_comb begin
         port_data = mem_q[addr];
         port_busy = busy_q[addr];
         if (zero_hit) begin
            port_data = '0;
            port_busy = 1'b0;
         end else if (byp_hit) begin
            // Forwarded data satisfies the dependency this cycle.
            port_data = wr_data;
            port_busy = 1'b0;
         end
      end

      assign rd_data[g*DATA_W +: DATA_W] = port_data;
      assign rd_busy[g]                  = port_busy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb

module tb_regfile_sb;

   logic        CLK;
   logic        RST_N;

   // Shared stimulus for the default (bypass) and no-bypass instances
   logic [9:0]  rd_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;

   logic [63:0] b_rd_data;
   logic [1:0]  b_rd_busy;
   logic [63:0] n_rd_data;
   logic [1:0]  n_rd_busy;

   // Wide instance: NREAD=4, DATA_W=64
   logic [19:0]  w_rd_addr;
   logic         w_wr_en;
   logic [4:0]   w_wr_addr;
   logic [63:0]  w_wr_data;
   logic         w_iss_en;
   logic [4:0]   w_iss_addr;
   logic [255:0] w_rd_data;
   logic [3:0]   w_rd_busy;

   int total;
   int bad;

   regfile_sb u_byp (
      .CLK(CLK), .RST_N(RST_N),
      .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr)
   );

   regfile_sb #(.BYPASS(0)) u_nob (
      .CLK(CLK), .RST_N(RST_N),
      .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr)
   );

   regfile_sb #(.NREAD(4), .DATA_W(64)) u_wide (
      .CLK(CLK), .RST_N(RST_N),
      .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
      .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
      .iss_en(w_iss_en), .iss_addr(w_iss_addr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
      w_wr_en  = 1'b0;
      w_iss_en = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b1;
      rd_addr = {5'd3, 5'd1};
      wr_addr = '0; wr_data = '0; iss_addr = '0;
      w_rd_addr = {5'd3, 5'd2, 5'd1, 5'd0};
      w_wr_addr = '0; w_wr_data = '0; w_iss_addr = '0;
      idle();
      #2 RST_N = 1'b0;
      #1;
      total++;
      if (b_rd_data !== 64'h0) begin
         bad++; $display("FAIL reset_in_data got=%h exp=%h", b_rd_data, 64'h0);
      end
      total++;
      if (b_rd_busy !== 2'b00) begin
         bad++; $display("FAIL reset_in_busy got=%b exp=%b", b_rd_busy, 2'b00);
      end
      step();
      step();
      RST_N = 1'b1;
      #1;
      total++;
      if (b_rd_data !== 64'h0 || n_rd_data !== 64'h0) begin
         bad++; $display("FAIL reset_out_data got=%h/%h exp=0", b_rd_data, n_rd_data);
      end
      total++;
      if (b_rd_busy !== 2'b00 || w_rd_busy !== 4'b0000) begin
         bad++; $display("FAIL reset_out_busy got=%b/%b exp=0", b_rd_busy, w_rd_busy);
      end
   endtask

   task automatic test_write_read();
      step();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
      step();
      idle();
      rd_addr = {5'd0, 5'd5};
      #1;
      total++;
      if (b_rd_data[31:0] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL wr_rd_byp got=%h exp=%h", b_rd_data[31:0], 32'hDEAD_BEEF);
      end
      total++;
      if (n_rd_data[31:0] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL wr_rd_nob got=%h exp=%h", n_rd_data[31:0], 32'hDEAD_BEEF);
      end
      // Write to r0 while reading r0: zero wins over forwarding
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      rd_addr = {5'd0, 5'd0};
      #1;
      total++;
      if (b_rd_data !== 64'h0) begin
         bad++; $display("FAIL r0_same_cycle got=%h exp=%h", b_rd_data, 64'h0);
      end
      step();
      idle();
      #1;
      total++;
      if (b_rd_data !== 64'h0 || n_rd_data !== 64'h0) begin
         bad++; $display("FAIL r0_after got=%h/%h exp=0", b_rd_data, n_rd_data);
      end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
      step();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2;
      rd_addr = {5'd7, 5'd7};
      #1;
      total++;
      if (b_rd_data !== {32'h2, 32'h2}) begin
         bad++; $display("FAIL bypass_on got=%h exp=%h", b_rd_data, {32'h2, 32'h2});
      end
      total++;
      if (n_rd_data !== {32'h1, 32'h1}) begin
         bad++; $display("FAIL bypass_off_now got=%h exp=%h", n_rd_data, {32'h1, 32'h1});
      end
      step();
      idle();
      #1;
      total++;
      if (n_rd_data !== {32'h2, 32'h2}) begin
         bad++; $display("FAIL bypass_off_next got=%h exp=%h", n_rd_data, {32'h2, 32'h2});
      end
   endtask

   task automatic test_scoreboard();
      iss_en = 1'b1; iss_addr = 5'd9;
      rd_addr = {5'd0, 5'd9};
      #1;
      total++;
      if (b_rd_busy !== 2'b00) begin
         bad++; $display("FAIL sb_before_edge got=%b exp=%b", b_rd_busy, 2'b00);
      end
      step();
      idle();
      #1;
      total++;
      if (b_rd_busy !== 2'b01 || n_rd_busy !== 2'b01) begin
         bad++; $display("FAIL sb_set got=%b/%b exp=01", b_rd_busy, n_rd_busy);
      end
      // Re-issue while busy: still busy, a single writeback clears it
      iss_en = 1'b1; iss_addr = 5'd9;
      step();
      idle();
      step();
      #1;
      total++;
      if (b_rd_busy !== 2'b01) begin
         bad++; $display("FAIL sb_held got=%b exp=%b", b_rd_busy, 2'b01);
      end
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      #1;
      total++;
      if (b_rd_busy !== 2'b00 || b_rd_data[31:0] !== 32'h55) begin
         bad++; $display("FAIL sb_wb_fwd got=%b/%h exp=00/00000055", b_rd_busy, b_rd_data[31:0]);
      end
      total++;
      if (n_rd_busy !== 2'b01 || n_rd_data[31:0] !== 32'h0) begin
         bad++; $display("FAIL sb_wb_nofwd got=%b/%h exp=01/00000000", n_rd_busy, n_rd_data[31:0]);
      end
      step();
      idle();
      #1;
      total++;
      if (b_rd_busy !== 2'b00 || n_rd_busy !== 2'b00 || b_rd_data[31:0] !== 32'h55) begin
         bad++; $display("FAIL sb_cleared got=%b/%b/%h exp=00/00/00000055", b_rd_busy, n_rd_busy, b_rd_data[31:0]);
      end
   endtask

   task automatic test_same_cycle();
      iss_en = 1'b1; iss_addr = 5'd4;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA;
      step();
      idle();
      rd_addr = {5'd4, 5'd4};
      #1;
      total++;
      if (b_rd_data !== {32'hA, 32'hA}) begin
         bad++; $display("FAIL same_data got=%h exp=%h", b_rd_data, {32'hA, 32'hA});
      end
      total++;
      if (b_rd_busy !== 2'b11) begin
         bad++; $display("FAIL same_busy got=%b exp=%b", b_rd_busy, 2'b11);
      end
      iss_en = 1'b1; iss_addr = 5'd0;
      step();
      idle();
      rd_addr = {5'd0, 5'd0};
      #1;
      total++;
      if (b_rd_busy !== 2'b00 || n_rd_busy !== 2'b00) begin
         bad++; $display("FAIL iss_r0 got=%b/%b exp=00", b_rd_busy, n_rd_busy);
      end
   endtask

   task automatic test_wide_ports();
      w_wr_en = 1'b1; w_wr_addr = 5'd2; w_wr_data = 64'h1122_3344_5566_7788;
      step();
      idle();
      w_iss_en = 1'b1; w_iss_addr = 5'd3;
      step();
      idle();
      // port0=2, port1=2, port2=3, port3=6 (forwarded this cycle)
      w_rd_addr = {5'd6, 5'd3, 5'd2, 5'd2};
      w_wr_en = 1'b1; w_wr_addr = 5'd6; w_wr_data = 64'hCAFE_F00D_0BAD_BEEF;
      #1;
      total++;
      if (w_rd_data !== {64'hCAFE_F00D_0BAD_BEEF, 64'h0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788}) begin
         bad++; $display("FAIL wide_data got=%h", w_rd_data);
      end
      total++;
      if (w_rd_busy !== 4'b0100) begin
         bad++; $display("FAIL wide_busy got=%b exp=%b", w_rd_busy, 4'b0100);
      end
      step();
      idle();
      #1;
      total++;
      if (w_rd_data[255:192] !== 64'hCAFE_F00D_0BAD_BEEF) begin
         bad++; $display("FAIL wide_stored got=%h exp=%h", w_rd_data[255:192], 64'hCAFE_F00D_0BAD_BEEF);
      end
   endtask

   task automatic test_async_reset();
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
      iss_en = 1'b1; iss_addr = 5'd3;
      step();
      idle();
      rd_addr = {5'd3, 5'd2};
      #1;
      total++;
      if (b_rd_data[31:0] !== 32'h77 || b_rd_busy !== 2'b10) begin
         bad++; $display("FAIL pre_rst got=%h/%b exp=00000077/10", b_rd_data[31:0], b_rd_busy);
      end
      #2;
      RST_N = 1'b0;
      #1;
      total++;
      if (b_rd_data !== 64'h0 || n_rd_data !== 64'h0 || w_rd_data !== 256'h0) begin
         bad++; $display("FAIL async_rst_data got=%h/%h/%h exp=0", b_rd_data, n_rd_data, w_rd_data);
      end
      total++;
      if (b_rd_busy !== 2'b00 || n_rd_busy !== 2'b00 || w_rd_busy !== 4'b0000) begin
         bad++; $display("FAIL async_rst_busy got=%b/%b/%b exp=0", b_rd_busy, n_rd_busy, w_rd_busy);
      end
      step();
      RST_N = 1'b1;
      #1;
      total++;
      if (b_rd_data !== 64'h0 || b_rd_busy !== 2'b00) begin
         bad++; $display("FAIL post_rst got=%h/%b exp=0/00", b_rd_data, b_rd_busy);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_same_cycle();
      test_wide_ports();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file for the pipelined seq core.
- Provides NREAD combinational read ports with the addresses packed into one bus, one synchronous write port, and optional write-to-read bypass.
- Includes a per-register scoreboard of busy bits. Decode uses it to detect reads of registers whose producing instruction has issued but not yet written back.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NREAD, 2, number of read ports (2 = rs/rt).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never goes busy.

Ports:
- CLK  in  1  clock, rising edge active.
- RST_N  in  1  reset, asynchronous, active-low.
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port i = rd_addr[i*ADDR_W +: ADDR_W] (port 0 = rs, port 1 = rt).
- rd_data  out  NREAD*DATA_W  packed read data; port i = rd_data[i*DATA_W +: DATA_W].
- rd_busy  out  NREAD  bit i = 1 when port i's register has a pending, not-yet-forwarded write.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  an instruction issues this cycle with destination iss_addr.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.

Behaviour:
- Clock and reset: one clock CLK; reset asynchronous active-low RST_N. RST_N low immediately clears every register to 0 and every busy bit to 0, including mid-operation. rd_data and rd_busy are combinational, so both read 0 while in reset and directly after.
- Storage: 2**ADDR_W x DATA_W. A write is committed at posedge CLK when wr_en=1. It is suppressed when ZERO_REG=1 and wr_addr=0.
- Read data, per port i with address a, evaluated combinationally with 0 cycles latency, in priority order:
  - ZERO_REG=1 and a=0 -> 0.
  - Else BYPASS=1, wr_en=1 and wr_addr=a -> wr_data.
  - Else stored value of register a.
- Multiple read ports with the same address return identical data.
- Scoreboard: busy[r] is updated at posedge CLK.
  - Set when iss_en=1 and iss_addr=r.
  - Cleared when wr_en=1 and wr_addr=r.
  - Issue and writeback to the same r in the same cycle: set wins (a newer producer has issued), and the data write still commits.
  - ZERO_REG=1: busy[0] is held at 0.
  - Issue to a register that is already busy: it stays busy; there is no counting. One writeback clears it.
- rd_busy[i] = busy[a] AND NOT (BYPASS=1 AND wr_en=1 AND wr_addr=a). A forwarded write is therefore never reported busy. With ZERO_REG=1 and a=0, rd_busy[i] is 0.
- The block itself never stalls. Stall generation is decode's job, using rd_busy.
- Widths: all address compares are ADDR_W bits exact; there is no wrap or masking. Data is passed unmodified.

Test Plan:
- Reset then idle: RST_N=0 then 1, with rd_addr={5'd3,5'd1} -> rd_data=0, rd_busy=2'b00.
- Write then read back, no bypass needed: wr r5=32'hDEAD_BEEF at edge 1, then rd_addr port0=5 in the next cycle -> rd_data port0=32'hDEAD_BEEF. Writing r0=32'hFFFF_FFFF and reading r0 -> 0.
- Bypass: r7 holds 32'h1; in one cycle wr_en=1, wr_addr=7, wr_data=32'h2, with both ports reading 7:
  - BYPASS=1 -> both ports 32'h2 in that same cycle.
  - BYPASS=0 -> 32'h1 in that cycle, 32'h2 the next cycle.
- Scoreboard lifecycle: iss r9 at edge 1 -> rd_busy for port reading 9 is 1 from edge 1. In a later cycle, wr r9=32'h55 (BYPASS=1): rd_busy=0 and rd_data=32'h55 in that cycle, and busy stays cleared after the edge.
- Simultaneous issue and writeback to r4: iss_en=1, iss_addr=4, wr_en=1, wr_addr=4, wr_data=32'hA at the same edge -> after the edge, r4 reads 32'hA and rd_busy=1. Issuing r0 leaves rd_busy=0.
- Async reset mid-operation: r2=32'h77 and busy[3]=1; pull RST_N low between clock edges -> rd_data=0 and rd_busy=0 immediately, without waiting for CLK. Repeat the checks with NREAD=4, DATA_W=64 to cover port packing.
